// File: rtl/adder_pkg.sv
// Shared defaults and result-flag type for the pipelined adder.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;

endpackage

// File: rtl/adder_stage.sv
// One pipeline stage: adds chunk IDX of the operands with the carry from the
// previous stage and registers the partial result alongside the pending operands.
module adder_stage
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             prev_valid,
  input  logic             prev_sub,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_sum,
  input  logic             prev_carry,
  input  logic             prev_zero,
  output logic             valid,
  output logic             sub,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LO   = IDX * CW;
  localparam bit LAST = (IDX == STAGES - 1);

  logic [CW-1:0]    a_chunk;
  logic [CW-1:0]    b_chunk;
  logic [CW-1:0]    s_chunk;
  logic             c_chunk;
  logic [WIDTH-1:0] sum_next;
  flags_t           flags_next;

  logic             valid_reg;
  logic             sub_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  flags_t           flags_reg;

  // B is inverted chunk by chunk with the delayed sub bit; stage 0 gets sub as carry-in.
  always_comb begin
    a_chunk = prev_a[LO +: CW];
    b_chunk = prev_b[LO +: CW] ^ {CW{prev_sub}};
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CW{1'b0}}, prev_carry};
    sum_next = prev_sum;
    sum_next[LO +: CW] = s_chunk;
    flags_next.carry    = c_chunk;
    flags_next.zero     = prev_zero && (s_chunk == '0);
    flags_next.overflow = LAST && (a_chunk[CW-1] == b_chunk[CW-1])
                          && (s_chunk[CW-1] != a_chunk[CW-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      sub_reg   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      flags_reg <= '0;
    end else if (en) begin
      valid_reg <= prev_valid;
      sub_reg   <= prev_sub;
      a_reg     <= prev_a;
      b_reg     <= prev_b;
      sum_reg   <= sum_next;
      flags_reg <= flags_next;
    end
  end

  assign valid    = valid_reg;
  assign sub      = sub_reg;
  assign a        = a_reg;
  assign b        = b_reg;
  assign sum      = sum_reg;
  assign carry    = flags_reg.carry;
  assign zero     = flags_reg.zero;
  assign overflow = flags_reg.overflow;

endmodule

// File: rtl/pipelined_adder.sv
// Carry-chained adder/subtractor split into STAGES chunk stages with a
// valid/ready handshake; the whole pipeline stalls on output backpressure.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero
);

  logic             advance;
  logic             valid_pipe [STAGES+1];
  logic             sub_pipe   [STAGES+1];
  logic             carry_pipe [STAGES+1];
  logic             zero_pipe  [STAGES+1];
  logic             ovf_pipe   [STAGES+1];
  logic [WIDTH-1:0] a_pipe     [STAGES+1];
  logic [WIDTH-1:0] b_pipe     [STAGES+1];
  logic [WIDTH-1:0] sum_pipe   [STAGES+1];

  assign valid_pipe[0] = in_valid;
  assign sub_pipe[0]   = in_sub;
  assign carry_pipe[0] = in_sub;
  assign zero_pipe[0]  = 1'b1;
  assign ovf_pipe[0]   = 1'b0;
  assign a_pipe[0]     = in_a;
  assign b_pipe[0]     = in_b;
  assign sum_pipe[0]   = '0;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      adder_stage #(
        .WIDTH (WIDTH),
        .STAGES(STAGES),
        .IDX   (gi)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (advance),
        .prev_valid(valid_pipe[gi]),
        .prev_sub  (sub_pipe[gi]),
        .prev_a    (a_pipe[gi]),
        .prev_b    (b_pipe[gi]),
        .prev_sum  (sum_pipe[gi]),
        .prev_carry(carry_pipe[gi]),
        .prev_zero (zero_pipe[gi]),
        .valid     (valid_pipe[gi+1]),
        .sub       (sub_pipe[gi+1]),
        .a         (a_pipe[gi+1]),
        .b         (b_pipe[gi+1]),
        .sum       (sum_pipe[gi+1]),
        .carry     (carry_pipe[gi+1]),
        .zero      (zero_pipe[gi+1]),
        .overflow  (ovf_pipe[gi+1])
      );
    end
  endgenerate

  // A full output slot with a stalled consumer freezes every stage, bubbles included.
  assign in_ready     = out_ready || !out_valid;
  assign advance      = in_ready;

  assign out_valid    = valid_pipe[STAGES];
  assign out_sum      = sum_pipe[STAGES];
  assign out_carry    = carry_pipe[STAGES];
  assign out_overflow = ovf_pipe[STAGES];
  assign out_zero     = zero_pipe[STAGES];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: a 32/4 instance for directed and random traffic, plus a
// sweep of other WIDTH/STAGES instances checked against a full-width model.
module tb_pipelined_adder;

  typedef logic [67:0] res_t;  // {pad, zero, overflow, carry, sum[63:0]}

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        has_exp;
    res_t        exp;
  } txn_t;

  int checks     = 0;
  int failures   = 0;
  int sweep_done = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_carry;
  logic        out_overflow;
  logic        out_zero;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_sub      (in_sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carry   (out_carry),
    .out_overflow(out_overflow),
    .out_zero    (out_zero)
  );

  task automatic check(input string tag, input res_t got, input res_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic res_t mk(logic [63:0] s, logic c, logic o, logic z);
    return {1'b0, z, o, c, s};
  endfunction

  function automatic res_t ref_add(int w, logic [63:0] a, logic [63:0] b, logic sub);
    logic [63:0] mask, am, bb, s;
    logic [64:0] full;
    logic        c, o, z;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bb   = (sub ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bb} + {64'd0, sub};
    s    = full[63:0] & mask;
    c    = full[w];
    o    = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
    z    = (s == 64'd0);
    return mk(s, c, o, z);
  endfunction

  function automatic int sweep_w(int i);
    case (i)
      0, 1:    return 8;
      2, 3:    return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int sweep_s(int i);
    case (i)
      0, 2, 4: return 1;
      1, 3, 5: return 2;
      default: return 8;
    endcase
  endfunction

  // ---------------- main instance driver / scoreboard ----------------
  txn_t src_q[$];
  res_t sb_q[$];
  logic drv_rst    = 1'b1;
  logic drv_oready = 1'b0;
  logic drv_src_en = 1'b1;
  logic hold_src   = 1'b0;
  logic stall_prev = 1'b0;
  res_t snap;
  int   out_cnt    = 0;

  function automatic res_t dut_res();
    return {1'b0, out_zero, out_overflow, out_carry, 32'd0, out_sum};
  endfunction

  task automatic push_exp(logic [31:0] a, logic [31:0] b, logic sub, res_t e);
    txn_t t;
    t.a = a; t.b = b; t.sub = sub; t.has_exp = 1'b1; t.exp = e;
    src_q.push_back(t);
  endtask

  task automatic push_rand();
    txn_t t;
    t.a = $urandom; t.b = $urandom; t.sub = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) t.b = t.a;
    t.has_exp = 1'b0; t.exp = '0;
    src_q.push_back(t);
  endtask

  task automatic cycle();
    txn_t t;
    res_t e;
    @(negedge clk);
    rst       = drv_rst;
    out_ready = drv_oready;
    if (src_q.size() > 0 && (drv_src_en || hold_src)) begin
      in_valid = 1'b1; in_a = src_q[0].a; in_b = src_q[0].b; in_sub = src_q[0].sub;
    end else begin
      in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
    end
    #1;
    check("in_ready", res_t'(in_ready), res_t'(out_ready || !out_valid));
    if (stall_prev) check("hold_stable", dut_res(), snap);
    if (rst) begin
      sb_q.delete();
      if (in_valid) void'(src_q.pop_front());
    end else begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb_q.size() == 0) check("unexpected_out", 68'd1, 68'd0);
        else check("result", dut_res(), sb_q.pop_front());
      end
      if (in_valid && in_ready) begin
        t = src_q.pop_front();
        e = t.has_exp ? t.exp : ref_add(32, {32'd0, t.a}, {32'd0, t.b}, t.sub);
        sb_q.push_back(e);
      end
    end
    hold_src   = in_valid && !in_ready && !rst;
    stall_prev = out_valid && !out_ready && !rst;
    snap       = dut_res();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    drv_oready = 1'b1;
    drv_src_en = 1'b1;
    while ((src_q.size() > 0 || sb_q.size() > 0) && n < 400) begin
      cycle();
      n++;
    end
    check(tag, res_t'(src_q.size() + sb_q.size()), 68'd0);
  endtask

  // Issues the head of src_q and counts cycles until out_valid rises.
  task automatic latency(input string tag);
    int n;
    drv_oready = 1'b1;
    cycle();
    n = 0;
    do begin
      cycle();
      n++;
    end while (!out_valid && n < 20);
    check(tag, res_t'(n), 68'd4);
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;

    // reset state
    drv_rst = 1'b1;
    cycle();
    cycle();
    drv_rst = 1'b0;
    cycle();
    check("rst_out_valid", res_t'(out_valid), 68'd0);
    check("rst_outputs", dut_res(), 68'd0);
    check("rst_in_ready", res_t'(in_ready), 68'd1);

    // basic add and its latency
    push_exp(32'd10, 32'd20, 1'b0, mk(64'd30, 1'b0, 1'b0, 1'b0));
    latency("latency_add");
    drain("drain_basic");

    // arithmetic corner cases
    push_exp(32'hFFFF_FFFF, 32'h1, 1'b0, mk(64'h0, 1'b1, 1'b0, 1'b1));
    push_exp(32'h7FFF_FFFF, 32'h1, 1'b0, mk(64'h8000_0000, 1'b0, 1'b1, 1'b0));
    push_exp(32'd5, 32'd7, 1'b1, mk(64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    push_exp(32'd7, 32'd5, 1'b1, mk(64'h2, 1'b1, 1'b0, 1'b0));
    push_exp(32'h8000_0000, 32'h1, 1'b1, mk(64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    push_exp(32'h0, 32'h0, 1'b1, mk(64'h0, 1'b1, 1'b0, 1'b1));
    push_exp(32'h0000_FFFF, 32'hFFFF_0001, 1'b0, mk(64'h0, 1'b1, 1'b0, 1'b1));
    drain("drain_corner");

    // backpressure: consumer stalls on cycles 3-5
    base = out_cnt;
    for (int i = 0; i < 8; i++)
      push_exp(32'(i), 32'd100, 1'b0, mk(64'(i + 100), 1'b0, 1'b0, 1'b0));
    for (int t = 0; t < 60 && (src_q.size() > 0 || sb_q.size() > 0); t++) begin
      drv_oready = !(t >= 3 && t <= 5);
      cycle();
    end
    check("bp_count", res_t'(out_cnt - base), 68'd8);

    // reset mid-flight; the third input coincides with reset and is dropped
    drv_oready = 1'b1;
    for (int i = 0; i < 3; i++)
      push_exp(32'(i + 1), 32'd1, 1'b0, mk(64'(i + 2), 1'b0, 1'b0, 1'b0));
    cycle();
    cycle();
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
    check("rst_src_flushed", res_t'(src_q.size()), 68'd0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("post_rst_valid", res_t'(out_valid), 68'd0);
    end
    push_exp(32'd3, 32'd4, 1'b0, mk(64'd7, 1'b0, 1'b0, 1'b0));
    latency("latency_post_rst");
    drain("drain_rst");

    // random traffic with random gaps and stalls
    for (int i = 0; i < 300; i++) push_rand();
    for (int n = 0; n < 2000 && src_q.size() > 0; n++) begin
      drv_src_en = ($urandom_range(0, 3) != 0);
      drv_oready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain("drain_random");

    for (int i = 0; i < 30000 && sweep_done < 7; i++) @(negedge clk);
    check("sweep_done", res_t'(sweep_done), 68'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- parameter sweep instances ----------------
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_sweep
      localparam int W = sweep_w(gi);
      localparam int S = sweep_s(gi);

      logic         rst_s, iv, ir, sub_s, ov, ordy, oc, oo, oz;
      logic [W-1:0] a_s, b_s, sum_s;
      res_t         sbq[$];

      pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk         (clk),
        .rst         (rst_s),
        .in_valid    (iv),
        .in_ready    (ir),
        .in_a        (a_s),
        .in_b        (b_s),
        .in_sub      (sub_s),
        .out_valid   (ov),
        .out_ready   (ordy),
        .out_sum     (sum_s),
        .out_carry   (oc),
        .out_overflow(oo),
        .out_zero    (oz)
      );

      function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 7))
          0:       v = 64'd0;
          1:       v = {64{1'b1}};
          2:       v = 64'd1 << (W - 1);
          default: v = {$urandom, $urandom};
        endcase
        return v;
      endfunction

      initial begin
        int          sent, got;
        logic        hold;
        logic [63:0] a64, b64, s64;
        sent = 0; got = 0; hold = 1'b0;
        rst_s = 1'b1; iv = 1'b0; ordy = 1'b0; a_s = '0; b_s = '0; sub_s = 1'b0;
        repeat (3) @(negedge clk);
        rst_s = 1'b0;
        for (int c = 0; c < 20000 && got < 1000; c++) begin
          @(negedge clk);
          ordy = ($urandom_range(0, 3) != 0);
          if (!hold) begin
            if (sent < 1000 && $urandom_range(0, 4) != 0) begin
              a64 = pick(); b64 = pick();
              iv = 1'b1; a_s = a64[W-1:0]; b_s = b64[W-1:0]; sub_s = 1'($urandom_range(0, 1));
            end else begin
              iv = 1'b0;
            end
          end
          #1;
          if (ov && ordy) begin
            s64 = '0;
            s64[W-1:0] = sum_s;
            got++;
            if (sbq.size() == 0) check($sformatf("sweep_w%0d_s%0d_extra", W, S), 68'd1, 68'd0);
            else check($sformatf("sweep_w%0d_s%0d", W, S), {1'b0, oz, oo, oc, s64}, sbq.pop_front());
          end
          if (iv && ir) begin
            a64 = '0; b64 = '0;
            a64[W-1:0] = a_s; b64[W-1:0] = b_s;
            sbq.push_back(ref_add(W, a64, b64, sub_s));
            sent++;
          end
          hold = iv && !ir;
        end
        check($sformatf("sweep_w%0d_s%0d_count", W, S), res_t'(got), 68'd1000);
        sweep_done++;
      end
    end
  endgenerate

endmodule
